// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse generate/shape/measure blocks.
// Optional timeout in pulse_measure: PULSE_MEASURE_TIMEOUT_EN.
package pulse_pkg;

  localparam int PULSE_CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } pulse_meas_state_t;

endpackage

// File: rtl/pulse_edge_det.sv
// Registered-history edge detector for a clk-synchronous pulse.
// Optional timeout in pulse_measure: PULSE_MEASURE_TIMEOUT_EN.
module pulse_edge_det (
  input  logic clk,
  input  logic clr,
  input  logic pulse_in,
  output logic rise,
  output logic fall
);

  logic pulse_d;

  // Clearing to 1 hides a pulse already high when measuring starts.
  always_ff @(posedge clk) begin
    if (clr) pulse_d <= 1'b1;
    else     pulse_d <= pulse_in;
  end

  assign rise = pulse_in & ~pulse_d;
  assign fall = ~pulse_in & pulse_d;

endmodule

// File: rtl/pulse_measure.sv
// Measures high width and rise-to-rise period of a synchronous pulse.
// Optional edge-gap timeout: define PULSE_MEASURE_TIMEOUT_EN.
module pulse_measure
  import pulse_pkg::*;
#(
  parameter int CNT_W  = PULSE_CNT_W_DEF,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              meas_en,
`ifdef PULSE_MEASURE_TIMEOUT_EN
  input  logic [CNT_W-1:0]  timeout_num,
  output logic              timeout,
`endif
  output logic [CNT_W-1:0]  width_out,
  output logic              width_vld,
  output logic [CNT_W-1:0]  period_out,
  output logic              period_vld,
  output logic [PCNT_W-1:0] pulse_cnt,
  output logic              ovf
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pulse_meas_state_t state;

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] p_inc;
  logic             w_full;
  logic             p_full;

  pulse_edge_det u_edge (
    .clk      (clk),
    .clr      (rst | ~meas_en),
    .pulse_in (pulse_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Counters park at all-ones; any further step flags overflow.
  assign w_full = &width_cnt;
  assign p_full = &period_cnt;
  assign w_inc  = w_full ? width_cnt : width_cnt + ONE;
  assign p_inc  = p_full ? period_cnt : period_cnt + ONE;

`ifdef PULSE_MEASURE_TIMEOUT_EN
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] gap_nxt;
  logic             gap_hit;

  assign gap_nxt = (&gap_cnt) ? gap_cnt : gap_cnt + ONE;
  assign gap_hit = (timeout_num != '0)
                 && (state != IDLE)
                 && !(rise | fall)
                 && !(&gap_cnt)
                 && (gap_nxt == timeout_num);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      width_cnt  <= '0;
      period_cnt <= '0;
      width_out  <= '0;
      period_out <= '0;
      width_vld  <= 1'b0;
      period_vld <= 1'b0;
      pulse_cnt  <= '0;
      ovf        <= 1'b0;
`ifdef PULSE_MEASURE_TIMEOUT_EN
      gap_cnt    <= '0;
      timeout    <= 1'b0;
`endif
    end else if (!meas_en) begin
      state      <= IDLE;
      width_vld  <= 1'b0;
      period_vld <= 1'b0;
      ovf        <= 1'b0;
`ifdef PULSE_MEASURE_TIMEOUT_EN
      gap_cnt    <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      width_vld  <= 1'b0;
      period_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            width_cnt  <= ONE;
            period_cnt <= ONE;
            state      <= HIGH;
          end
        end
        HIGH: begin
          period_cnt <= p_inc;
          if (p_full) ovf <= 1'b1;
          if (fall) begin
            width_out <= width_cnt;
            width_vld <= 1'b1;
            pulse_cnt <= pulse_cnt + PCNT_W'(1);
            state     <= LOW;
          end else begin
            width_cnt <= w_inc;
            if (w_full) ovf <= 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            period_out <= period_cnt;
            period_vld <= 1'b1;
            width_cnt  <= ONE;
            period_cnt <= ONE;
            state      <= HIGH;
          end else begin
            period_cnt <= p_inc;
            if (p_full) ovf <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef PULSE_MEASURE_TIMEOUT_EN
      // A timed-out pulse is abandoned; the next rise has no reference.
      timeout <= gap_hit;
      if (state == IDLE || rise || fall || gap_hit) gap_cnt <= '0;
      else                                          gap_cnt <= gap_nxt;
      if (gap_hit) state <= WAIT_RISE;
`endif
    end
  end

endmodule
